hdmi_src_sched: RTL and testbench

Frame-synchronous pixel-source scheduler in front of `hdmi_if`. It shares the single HDMI pixel path between two streaming requesters and a built-in colour-bar pattern. It consumes `hdmi_if`'s `hcount`/`vcount`/`dat_rdy` and drives its `dat_in`. Source switches happen only at frame boundaries, and the block reports underflow and frame misalignment.

---
 rtl/hdmi_src_sched_pkg.sv | 39 +++
 rtl/hdmi_src_sched_colorbar_gen.sv | 58 +++++
 rtl/hdmi_src_sched.sv | 138 +++++++++++++
 tb/tb_hdmi_src_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_src_sched_pkg.sv
// Shared definitions for the HDMI pixel-source scheduler: owner codes,
// FSM states and the colour-bar palette.
package hdmi_src_sched_pkg;

   localparam logic [1:0] SEL_PAT = 2'd0;
   localparam logic [1:0] SEL_S0  = 2'd1;
   localparam logic [1:0] SEL_S1  = 2'd2;

   typedef enum logic [1:0] {
      ST_PAT   = 2'd0,
      ST_ALIGN = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   function automatic logic [23:0] bar_color(input logic [2:0] bar);
      logic [23:0] c;
      case (bar)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/hdmi_src_sched_colorbar_gen.sv
// Eight-bar vertical colour pattern; counters restart on the first active
// pixel of every line and advance only on pixel requests.
module colorbar_gen
   import hdmi_src_sched_pkg::*;
#(
   parameter int H_ACT      = 1280,
   parameter int H_FIRST    = 0,
   parameter int CNT_HSYC_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dat_rdy,
   input  logic [CNT_HSYC_W-1:0] hcount,
   output logic [23:0]           pat_pix
);

   localparam int BAR_W = H_ACT / 8;
   localparam int PIX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   logic [PIX_W-1:0] pix_q, pix_d, pix_cur;
   logic [2:0]       bar_q, bar_d, bar_cur;
   logic             line_start;

   assign line_start = dat_rdy && (hcount == CNT_HSYC_W'(H_FIRST));

   // NOTE: every variable gets a default at the top so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      pix_cur = line_start ? '0 : pix_q;
      bar_cur = line_start ? '0 : bar_q;
      pix_d   = pix_q;
      bar_d   = bar_q;
      if (dat_rdy) begin
         if (pix_cur == PIX_W'(BAR_W - 1)) begin
            pix_d = '0;
            bar_d = bar_cur + 3'd1;
         end else begin
            pix_d = pix_cur + PIX_W'(1);
            bar_d = bar_cur;
         end
      end
   end

   assign pat_pix = bar_color(bar_cur);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q <= '0;
         bar_q <= '0;
      end else begin
         pix_q <= pix_d;
         bar_q <= bar_d;
      end
   end

endmodule

// File: rtl/hdmi_src_sched.sv
// Frame-synchronous owner arbitration of the HDMI pixel path between two
// streaming sources and the built-in colour bars.
module hdmi_src_sched
   import hdmi_src_sched_pkg::*;
#(
   parameter int H_ACT      = 1280,
   parameter int H_FIRST    = 0,
   parameter int V_FIRST    = 0,
   parameter int CNT_HSYC_W = 12,
   parameter int CNT_VSYC_W = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CNT_HSYC_W-1:0] hcount,
   input  logic [CNT_VSYC_W-1:0] vcount,
   input  logic                  dat_rdy,
   output logic [23:0]           dat_out,
   input  logic                  s0_req,
   input  logic                  s1_req,
   input  logic                  s0_vld,
   input  logic                  s1_vld,
   input  logic                  s0_sof,
   input  logic                  s1_sof,
   input  logic [23:0]           s0_dat,
   input  logic [23:0]           s1_dat,
   output logic                  s0_rdy,
   output logic                  s1_rdy,
   output logic [1:0]            cur_sel,
   output logic                  ufl,
   output logic                  mis,
   input  logic                  stat_clr
);

   state_e      state_q, state_d;
   logic [1:0]  sel_q, sel_d, nxt_sel;
   logic [23:0] dat_out_q, dat_out_d, pat_pix, pix;
   logic        ufl_q, ufl_d, mis_q, mis_d;
   logic        fb, g_vld, g_sof, g_rdy, ufl_set, mis_set, hold_beat;
   logic [23:0] g_dat;

   colorbar_gen #(
      .H_ACT      (H_ACT),
      .H_FIRST    (H_FIRST),
      .CNT_HSYC_W (CNT_HSYC_W)
   ) u_colorbar (
      .clk     (clk),
      .rst_n   (rst_n),
      .dat_rdy (dat_rdy),
      .hcount  (hcount),
      .pat_pix (pat_pix)
   );

   assign fb = dat_rdy && (hcount == CNT_HSYC_W'(H_FIRST))
                       && (vcount == CNT_VSYC_W'(V_FIRST));
   assign nxt_sel = s0_req ? SEL_S0 : (s1_req ? SEL_S1 : SEL_PAT);

   // The frame-boundary beat is already served by the new owner.
   always_comb begin
      sel_d = fb ? nxt_sel : sel_q;
   end

   always_comb begin
      g_vld = 1'b0;
      g_sof = 1'b0;
      g_dat = '0;
      case (sel_d)
         SEL_S0:  begin g_vld = s0_vld; g_sof = s0_sof; g_dat = s0_dat; end
         SEL_S1:  begin g_vld = s1_vld; g_sof = s1_sof; g_dat = s1_dat; end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      mis_set   = 1'b0;
      hold_beat = 1'b0;
      if (fb) begin
         if (nxt_sel == SEL_PAT) begin
            state_d = ST_PAT;
         end else if (nxt_sel != sel_q) begin
            state_d = ST_ALIGN;
         end else if (state_q == ST_ALIGN && g_vld && g_sof) begin
            state_d = ST_RUN;
         end else if (state_q == ST_RUN && g_vld && !g_sof) begin
            // Source lost frame lock: fall back to pattern, leave the beat in place.
            state_d   = ST_ALIGN;
            mis_set   = 1'b1;
            hold_beat = 1'b1;
         end
      end
   end

   always_comb begin
      g_rdy   = 1'b0;
      pix     = pat_pix;
      ufl_set = 1'b0;
      case (state_d)
         ST_ALIGN: g_rdy = g_vld && !g_sof && !hold_beat;
         ST_RUN: begin
            g_rdy = dat_rdy;
            if (g_vld) begin
               pix = g_dat;
            end else begin
               pix     = '0;
               ufl_set = dat_rdy;
            end
         end
         default: ;
      endcase
      dat_out_d = dat_rdy ? pix : dat_out_q;
      ufl_d     = ufl_set || (ufl_q && !stat_clr);
      mis_d     = mis_set || (mis_q && !stat_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_PAT;
         sel_q     <= SEL_PAT;
         dat_out_q <= '0;
         ufl_q     <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         dat_out_q <= dat_out_d;
         ufl_q     <= ufl_d;
         mis_q     <= mis_d;
      end
   end

   assign s0_rdy  = (sel_d == SEL_S0) && g_rdy;
   assign s1_rdy  = (sel_d == SEL_S1) && g_rdy;
   assign cur_sel = sel_q;
   assign dat_out = dat_out_q;
   assign ufl     = ufl_q;
   assign mis     = mis_q;

endmodule

// File: tb/tb_hdmi_src_sched.sv
// Self-checking bench for hdmi_src_sched: a small raster (16x2 active inside
// 20x3 total) with two counting sources and a dat_out scoreboard.
module tb_hdmi_src_sched;

   localparam int H_ACT = 16;
   localparam int H_TOT = 20;
   localparam int V_ACT = 2;
   localparam int V_TOT = 3;
   localparam int FRAME = H_TOT * V_TOT;
   localparam int FRAME_PIX = H_ACT * V_ACT;
   localparam logic [23:0] S0_BASE = 24'hA00000;
   localparam logic [23:0] S1_BASE = 24'h123456;

   typedef enum int {M_PAT, M_S0, M_S1} mode_e;
   typedef struct {
      logic [11:0] h;
      logic [23:0] pix;
   } vec_t;

   logic        clk, rst_n;
   logic [11:0] hcount;
   logic [10:0] vcount;
   logic        dat_rdy;
   logic [23:0] dat_out;
   logic        s0_req, s1_req, s0_vld, s1_vld, s0_sof, s1_sof;
   logic [23:0] s0_dat, s1_dat;
   logic        s0_rdy, s1_rdy;
   logic [1:0]  cur_sel;
   logic        ufl, mis, stat_clr;

   vec_t        pat_tbl[16];
   logic [23:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          n_rdy0 = 0, n_rdy1 = 0;
   int          pat_k = 0, run_k = 0;
   mode_e       mode = M_PAT;
   logic        s0_en = 1'b0, s1_en = 1'b0, s0_stall = 1'b0;
   int          s0_pos = 0, s1_pos = 0;
   logic [7:0]  s0_fr = 8'd0, s1_fr = 8'd0;
   int          base0, base1;

   hdmi_src_sched #(
      .H_ACT      (H_ACT),
      .H_FIRST    (0),
      .V_FIRST    (0),
      .CNT_HSYC_W (12),
      .CNT_VSYC_W (11)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .hcount   (hcount),
      .vcount   (vcount),
      .dat_rdy  (dat_rdy),
      .dat_out  (dat_out),
      .s0_req   (s0_req),
      .s1_req   (s1_req),
      .s0_vld   (s0_vld),
      .s1_vld   (s1_vld),
      .s0_sof   (s0_sof),
      .s1_sof   (s1_sof),
      .s0_dat   (s0_dat),
      .s1_dat   (s1_dat),
      .s0_rdy   (s0_rdy),
      .s1_rdy   (s1_rdy),
      .cur_sel  (cur_sel),
      .ufl      (ufl),
      .mis      (mis),
      .stat_clr (stat_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // One pixel-clock cycle: drive raster and sources, queue the expected
   // pixel for a requested beat, then compare it after the edge.
   task automatic cycle(input int h, input int v, input logic act);
      logic [23:0] want, got_want;
      logic        took0, took1;
      hcount  = 12'(h);
      vcount  = 11'(v);
      dat_rdy = act;
      s0_vld  = s0_en && !s0_stall;
      s0_sof  = (s0_pos == 0);
      s0_dat  = S0_BASE + {8'h00, s0_fr, 8'h00} + 24'(s0_pos);
      s1_vld  = s1_en;
      s1_sof  = (s1_pos == 0);
      s1_dat  = S1_BASE + {8'h00, s1_fr, 8'h00} + 24'(s1_pos);
      #1;
      took0 = s0_vld && s0_rdy;
      took1 = s1_vld && s1_rdy;
      if (s0_rdy) n_rdy0++;
      if (s1_rdy) n_rdy1++;
      if (act) begin
         if (h == 0) pat_k = 0;
         if (h == 0 && v == 0) run_k = 0;
         case (mode)
            M_S0: begin
               if (s0_stall) want = 24'h000000;
               else begin
                  want = S0_BASE + {8'h00, s0_fr, 8'h00} + 24'(run_k);
                  run_k++;
               end
            end
            M_S1: begin
               want = S1_BASE + {8'h00, s1_fr, 8'h00} + 24'(run_k);
               run_k++;
            end
            default: want = pat_tbl[pat_k].pix;
         endcase
         pat_k = (pat_k + 1) % 16;
         exp_q.push_back(want);
      end
      @(posedge clk);
      #1;
      if (took0) begin
         if (s0_pos == FRAME_PIX - 1) begin s0_pos = 0; s0_fr++; end
         else s0_pos++;
      end
      if (took1) begin
         if (s1_pos == FRAME_PIX - 1) begin s1_pos = 0; s1_fr++; end
         else s1_pos++;
      end
      if (act) begin
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=none want=pixel");
         end else begin
            got_want = exp_q.pop_front();
            check("dat_out", 32'(dat_out), 32'(got_want));
         end
      end
   endtask

   task automatic raster(input int c);
      cycle(c % H_TOT, c / H_TOT, ((c % H_TOT) < H_ACT) && ((c / H_TOT) < V_ACT));
   endtask

   initial begin
      logic [23:0] bars[8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      for (int i = 0; i < 16; i++) begin
         pat_tbl[i].h   = 12'(i);
         pat_tbl[i].pix = bars[i / 2];
      end

      rst_n = 1'b0; hcount = '0; vcount = '0; dat_rdy = 1'b0;
      s0_req = 1'b0; s1_req = 1'b0; s0_vld = 1'b0; s1_vld = 1'b0;
      s0_sof = 1'b0; s1_sof = 1'b0; s0_dat = '0; s1_dat = '0; stat_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dat_out", 32'(dat_out), 32'h0);
      check("rst_cur_sel", 32'(cur_sel), 32'd0);
      check("rst_ufl", 32'(ufl), 32'd0);
      check("rst_mis", 32'(mis), 32'd0);
      check("rst_s0_rdy", 32'(s0_rdy), 32'd0);
      check("rst_s1_rdy", 32'(s1_rdy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: no requests, two back-to-back active lines of colour bars
      mode = M_PAT;
      for (int ln = 0; ln < 2; ln++)
         for (int i = 0; i < 16; i++) cycle(int'(pat_tbl[i].h), ln, 1'b1);
      check("t1_cur_sel", 32'(cur_sel), 32'd0);

      // 2: s1 requests mid-frame, aligns, then streams from its sof
      s1_en = 1'b1;
      for (int c = 0; c < FRAME; c++) begin
         if (c == 10) s1_req = 1'b1;
         raster(c);
      end
      check("t2_sel_before_fb", 32'(cur_sel), 32'd0);
      base1 = n_rdy1;
      for (int c = 0; c < FRAME; c++) begin
         raster(c);
         if (c == 0) check("t2_sel_align", 32'(cur_sel), 32'd2);
      end
      check("t2_sof_parked_rdy", 32'(n_rdy1 - base1), 32'd0);
      check("t2_sof_parked_pos", 32'(s1_pos), 32'd0);
      mode = M_S1;
      base1 = n_rdy1;
      for (int c = 0; c < FRAME; c++) raster(c);
      check("t2_consumed", 32'(n_rdy1 - base1), 32'(FRAME_PIX));
      check("t2_s1_frame", 32'(s1_fr), 32'd1);

      // 3: both request at the boundary, s0 wins
      mode = M_PAT;
      s0_en = 1'b1;
      s0_req = 1'b1;
      base1 = n_rdy1;
      for (int c = 0; c < FRAME; c++) begin
         raster(c);
         if (c == 0) check("t3_sel_s0", 32'(cur_sel), 32'd1);
      end
      mode = M_S0;
      for (int c = 0; c < FRAME; c++) raster(c);
      check("t3_s1_rdy_low", 32'(n_rdy1 - base1), 32'd0);

      // 4: underflow beats, flag clear alone, and clear racing a new underflow
      for (int c = 0; c < FRAME; c++) begin
         s0_stall = (c == 5 || c == 6 || c == 7 || c == 23);
         stat_clr = (c == 17 || c == 23);
         raster(c);
         if (c == 4)  check("t4_ufl_clear_before", 32'(ufl), 32'd0);
         if (c == 7)  check("t4_ufl_set", 32'(ufl), 32'd1);
         if (c == 17) check("t4_ufl_cleared", 32'(ufl), 32'd0);
         if (c == 23) check("t4_ufl_set_wins", 32'(ufl), 32'd1);
      end
      s0_stall = 1'b0;
      stat_clr = 1'b0;
      check("t4_mis_clear", 32'(mis), 32'd0);

      // 5: the shortened frame leaves s0 mid-frame at the next boundary
      mode = M_PAT;
      base0 = n_rdy0;
      for (int c = 0; c < FRAME; c++) begin
         raster(c);
         if (c == 0) begin
            check("t5_fb_beat_kept", 32'(n_rdy0 - base0), 32'd0);
            check("t5_mis_set", 32'(mis), 32'd1);
            check("t5_sel_kept", 32'(cur_sel), 32'd1);
         end
      end
      check("t5_discarded", 32'(n_rdy0 - base0), 32'd4);
      check("t5_sof_parked", 32'(s0_pos), 32'd0);
      mode = M_S0;
      for (int c = 0; c < FRAME; c++) begin
         stat_clr = (c == 50);
         raster(c);
         if (c == 50) begin
            check("t5_ufl_cleared", 32'(ufl), 32'd0);
            check("t5_mis_cleared", 32'(mis), 32'd0);
         end
      end
      stat_clr = 1'b0;

      // 6: asynchronous reset in the middle of a running frame
      for (int c = 0; c < FRAME; c++) begin
         s0_stall = (c == 3);
         raster(c);
         if (c == 3) check("t6_ufl_before_rst", 32'(ufl), 32'd1);
         if (c == 25) begin
            #2 rst_n = 1'b0;
            #1;
            check("t6_rst_dat_out", 32'(dat_out), 32'h0);
            check("t6_rst_cur_sel", 32'(cur_sel), 32'd0);
            check("t6_rst_ufl", 32'(ufl), 32'd0);
            check("t6_rst_mis", 32'(mis), 32'd0);
            check("t6_rst_s0_rdy", 32'(s0_rdy), 32'd0);
            dat_rdy = 1'b0;
            mode = M_PAT;
            pat_k = 0;
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
         end
      end
      s0_stall = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
         raster(c);
         if (c == 0) check("t6_regain_s0", 32'(cur_sel), 32'd1);
      end
      check("t6_realigned_sof", 32'(s0_pos), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
